// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the graph-memory read arbiters.
package arbitro_pkg;

  // Tag width covers the widest supported requester count.
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef enum logic {
    ST_LIVRE   = 1'b0,
    ST_TRAVADO = 1'b1
  } estado_t;

  function automatic logic [TAG_W-1:0] onehot_para_indice(
    input logic [MAX_REQ-1:0] oh
  );
    logic [TAG_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) r = r | TAG_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/arbitro_leitura_grafo_seletor.sv
// Combinational round-robin pick: first unmasked request at or after ptr.
module seletor_round_robin
  import arbitro_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant,
  output logic [TAG_W-1:0] idx
);

  logic [N-1:0]       ativo;
  logic [N-1:0]       rot;
  logic [MAX_REQ-1:0] grant_ext;
  logic               achou;
  int                 off;
  int                 alvo;

  always_comb begin
    ativo = req & ~mask;
    rot   = N'({ativo, ativo} >> ptr);
    achou = 1'b0;
    off   = 0;
    for (int i = 0; i < N; i++) begin
      if (!achou && rot[i]) begin
        achou = 1'b1;
        off   = i;
      end
    end
    alvo = int'(ptr) + off;
    if (alvo >= N) alvo = alvo - N;
    grant     = achou ? (N'(1) << alvo) : '0;
    grant_ext = MAX_REQ'(grant);
    idx       = onehot_para_indice(grant_ext);
  end

endmodule

// File: rtl/arbitro_leitura_grafo.sv
// Round-robin arbiter with locked bursts sharing one graph-memory read port.
module arbitro_leitura_grafo
  import arbitro_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 48,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ-1:0]            req_lock_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic                          mem_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr_out,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data_in,
  output logic                          arb_ocioso_out
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  estado_t          state, state_nxt;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] owner, owner_nxt;
  logic [CW-1:0]    lock_cnt, cnt_nxt;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [TAG_W-1:0]   sel_idx;
  logic [TAG_W-1:0]   win_idx;
  logic               lock_owner;
  logic               timeout;
  logic               fixo;
  logic               outros;
  logic               accept;
  logic               lock_win;

  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [RD_LATENCY:0]   tag_v;
  logic [TAG_W-1:0]      tag_i [RD_LATENCY+1];

  assign owner_oh   = NUM_REQ'(1) << owner;
  assign lock_owner = |(req_lock_in & owner_oh);
  assign timeout    = (state == ST_TRAVADO) &&
                      (lock_cnt == CW'(MAX_LOCK));
  // Owner keeps exclusive access until it drops lock or hits the bound.
  assign fixo       = (state == ST_TRAVADO) && lock_owner && !timeout;
  assign outros     = |(req_valid_in & ~owner_oh);
  assign mask       = (timeout && outros) ? owner_oh : '0;

  seletor_round_robin #(
    .N (NUM_REQ)
  ) u_sel (
    .req   (req_valid_in),
    .ptr   (rr_ptr),
    .mask  (mask),
    .grant (grant),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LIVRE;
      owner    <= '0;
      lock_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
      if (accept)
        rr_ptr <= (win_idx == TAG_W'(NUM_REQ - 1)) ?
                  '0 : win_idx + TAG_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    if (fixo) begin
      if (accept) cnt_nxt = lock_cnt + CW'(1);
    end else if (accept && lock_win) begin
      state_nxt = ST_TRAVADO;
      owner_nxt = sel_idx;
      cnt_nxt   = CW'(1);
    end else if (accept || state == ST_TRAVADO) begin
      state_nxt = ST_LIVRE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    ready    = fixo ? (req_valid_in & owner_oh) : grant;
    win_idx  = fixo ? owner : sel_idx;
    accept   = |ready;
    lock_win = |(req_lock_in & ready);
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ready[i])
        addr_sel = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign req_ready_out = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_enable_out <= 1'b0;
      mem_rd_addr_out   <= '0;
      tag_v             <= '0;
      for (int k = 0; k <= RD_LATENCY; k++)
        tag_i[k] <= '0;
      rsp_valid_out     <= '0;
      rsp_data_out      <= '0;
    end else begin
      mem_rd_enable_out <= accept;
      if (accept) mem_rd_addr_out <= addr_sel;
      tag_v    <= {tag_v[RD_LATENCY-1:0], accept};
      tag_i[0] <= win_idx;
      for (int k = 1; k <= RD_LATENCY; k++)
        tag_i[k] <= tag_i[k-1];
      rsp_valid_out <= tag_v[RD_LATENCY] ?
                       (NUM_REQ'(1) << tag_i[RD_LATENCY]) : '0;
      if (tag_v[RD_LATENCY]) rsp_data_out <= mem_rd_data_in;
    end
  end

  assign arb_ocioso_out = (state == ST_LIVRE) &&
                          !(|req_valid_in) && !(|tag_v);

endmodule

// File: tb/tb_arbitro_leitura_grafo.sv
// Directed bench for arbitro_leitura_grafo with a 1-cycle memory model.
module tb_arbitro_leitura_grafo;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N-1:0]    req_lock_in;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    rsp_valid_out;
  logic [DW-1:0]   rsp_data_out;
  logic            mem_rd_enable_out;
  logic [AW-1:0]   mem_rd_addr_out;
  logic [DW-1:0]   mem_rd_data_in;
  logic            arb_ocioso_out;

  arbitro_leitura_grafo #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (1),
    .MAX_LOCK   (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_in      (req_valid_in),
    .req_addr_in       (req_addr_in),
    .req_lock_in       (req_lock_in),
    .req_ready_out     (req_ready_out),
    .rsp_valid_out     (rsp_valid_out),
    .rsp_data_out      (rsp_data_out),
    .mem_rd_enable_out (mem_rd_enable_out),
    .mem_rd_addr_out   (mem_rd_addr_out),
    .mem_rd_data_in    (mem_rd_data_in),
    .arb_ocioso_out    (arb_ocioso_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 48'hA92 + DW'(a);
  endfunction

  initial mem_rd_data_in = '0;
  always @(posedge clk)
    if (mem_rd_enable_out) mem_rd_data_in <= mem_f(mem_rd_addr_out);

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] tv [32];
  logic [N-1:0] tl [32];
  logic [N-1:0] te [32];

  task automatic checa(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_de(input logic [N-1:0] oh);
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++)
      if (oh[i]) a = req_addr_in[i*AW +: AW];
    return a;
  endfunction

  task automatic reinicia();
    rst          = 1'b1;
    req_valid_in = '0;
    req_lock_in  = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic ciclo(input string tag, input logic [N-1:0] v,
                       input logic [N-1:0] l, input logic [N-1:0] er,
                       input logic [N-1:0] ers);
    req_valid_in = v;
    req_lock_in  = l;
    @(negedge clk);
    checa({tag, "_rdy"}, 64'(req_ready_out), 64'(er));
    checa({tag, "_rsp"}, 64'(rsp_valid_out), 64'(ers));
    if (ers != '0)
      checa({tag, "_dat"}, 64'(rsp_data_out), 64'(mem_f(addr_de(ers))));
    @(posedge clk);
    #1;
  endtask

  task automatic roda(input string tag, input int n);
    for (int k = 0; k < n; k++)
      ciclo($sformatf("%s_%0d", tag, k), tv[k], tl[k], te[k],
            (k >= 3) ? te[k-3] : '0);
  endtask

  initial begin
    req_addr_in = {8'h43, 8'h42, 8'h41, 8'h2A};
    reinicia();

    @(negedge clk);
    checa("rst_en", 64'(mem_rd_enable_out), 64'd0);
    checa("rst_rsp", 64'(rsp_valid_out), 64'd0);
    checa("rst_dat", 64'(rsp_data_out), 64'd0);
    checa("rst_idle", 64'(arb_ocioso_out), 64'd1);
    @(posedge clk);
    #1;

    // single request
    req_valid_in = 4'b0001;
    @(negedge clk);
    checa("s_rdy", 64'(req_ready_out), 64'b0001);
    @(posedge clk);
    #1 req_valid_in = '0;
    @(negedge clk);
    checa("s_en", 64'(mem_rd_enable_out), 64'd1);
    checa("s_addr", 64'(mem_rd_addr_out), 64'h2A);
    checa("s_idle_busy", 64'(arb_ocioso_out), 64'd0);
    @(negedge clk);
    checa("s_en2", 64'(mem_rd_enable_out), 64'd0);
    checa("s_rsp_early", 64'(rsp_valid_out), 64'd0);
    @(negedge clk);
    checa("s_rsp", 64'(rsp_valid_out), 64'b0001);
    checa("s_dat", 64'(rsp_data_out), 64'hABC);
    @(negedge clk);
    checa("s_rsp_off", 64'(rsp_valid_out), 64'd0);
    checa("s_dat_hold", 64'(rsp_data_out), 64'hABC);
    checa("s_addr_hold", 64'(mem_rd_addr_out), 64'h2A);
    checa("s_idle", 64'(arb_ocioso_out), 64'd1);
    @(posedge clk);
    #1;

    // fairness
    reinicia();
    for (int k = 0; k < 9; k++) begin
      tv[k] = (k < 6) ? 4'hF : 4'h0;
      tl[k] = 4'h0;
      te[k] = (k < 6) ? (4'b0001 << (k % 4)) : 4'h0;
    end
    roda("rr", 9);

    // locked burst
    reinicia();
    for (int k = 0; k < 10; k++) begin
      tv[k] = (k == 0) ? 4'b0100 : (k < 8 ? 4'b0101 : 4'b0000);
      tl[k] = (k < 6) ? 4'b0100 : 4'b0000;
      te[k] = (k < 6) ? 4'b0100 :
              (k == 6 ? 4'b0001 : (k == 7 ? 4'b0100 : 4'b0000));
    end
    roda("lk", 10);

    // lock timeout
    reinicia();
    for (int k = 0; k < 22; k++) begin
      tv[k] = (k == 0) ? 4'b0010 :
              (k <= 10 ? 4'b1010 : (k < 18 ? 4'b0010 : 4'b1010));
      tl[k] = (k < 19) ? 4'b0010 : 4'b0000;
      te[k] = (k == 8) ? 4'b1000 : 4'b0010;
    end
    roda("to", 19);

    // reset mid-flight
    reinicia();
    req_valid_in = 4'b0001;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid_in = '0;
    @(negedge clk);
    checa("mf_en", 64'(mem_rd_enable_out), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checa("mf_en0", 64'(mem_rd_enable_out), 64'd0);
    @(negedge clk);
    checa("mf_rsp", 64'(rsp_valid_out), 64'd0);
    checa("mf_dat", 64'(rsp_data_out), 64'd0);
    checa("mf_addr", 64'(mem_rd_addr_out), 64'd0);
    checa("mf_idle", 64'(arb_ocioso_out), 64'd1);
    @(posedge clk);
    #1;

    // lock held without valid
    reinicia();
    for (int k = 0; k < 7; k++) begin
      tv[k] = (k == 0) ? 4'b0001 : 4'b0010;
      tl[k] = (k < 6) ? 4'b0001 : 4'b0000;
      te[k] = (k == 0) ? 4'b0001 : (k < 6 ? 4'b0000 : 4'b0010);
    end
    roda("nv", 7);

    // locked owner idle still counts as busy
    reinicia();
    ciclo("ho0", 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    req_valid_in = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checa("ho_idle", 64'(arb_ocioso_out), 64'd0);
    @(posedge clk);
    #1;
    ciclo("ho1", 4'b0011, 4'b0001, 4'b0001, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
